// File: rtl/mmio_ctrl_if.sv
// Data-memory-side bus between the core and mmio_ctrl.
// The core drives address/data/strobe; the controller returns select and read data.
interface mmio_ctrl_if #(
    parameter int unsigned DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] din;
    logic             we;
    logic [DBITS-1:0] dout;
    logic             sel;

    modport master (output addr, output din, output we, input dout, input sel);
    modport slave  (input addr, input din, input we, output dout, output sel);
endinterface

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller: HEX/LEDR/LEDG registers, synchronised switches, debounced keys
// with sticky press status. Optional free-running timer compiled in with `define MMIO_TIMER_EN.
module mmio_ctrl #(
    parameter int unsigned     DBITS   = 16,
    parameter logic [DBITS-1:0] ABASE  = 16'hFFF0,
    parameter int unsigned     NKEYS   = 4,
    parameter int unsigned     NSW     = 10,
    parameter int unsigned     NLEDR   = 10,
    parameter int unsigned     NLEDG   = 8,
    parameter int unsigned     NDIGITS = 4,
    parameter int unsigned     DEBBITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_ctrl_if.slave           bus,
    input  logic [NKEYS-1:0]     key,
    input  logic [NSW-1:0]       sw,
    output logic [4*NDIGITS-1:0] hexout,
    output logic [NLEDR-1:0]     ledr,
    output logic [NLEDG-1:0]     ledg,
    output logic                 irq
);

    typedef enum logic [2:0] {
        R_HEX    = 3'd0,
        R_LEDR   = 3'd1,
        R_LEDG   = 3'd2,
        R_KDATA  = 3'd3,
        R_SWDATA = 3'd4,
        R_KSTAT  = 3'd5,
        R_TCNT   = 3'd6,
        R_TLIM   = 3'd7
    } reg_e;

    reg_e             idx;
    logic             wr;
    logic [DBITS-1:0] rdata;

    logic [NSW-1:0]     sw_meta, sw_sync;
    logic [NKEYS-1:0]   key_meta, key_sync;
    logic [NKEYS-1:0]   kdata, kstat, kstat_clr, key_press;
    logic [DEBBITS-1:0] deb_cnt [NKEYS];
    logic               tstat;

    logic unused_bits;
    assign unused_bits = ^{bus.addr[0], bus.din};

    assign bus.sel = (bus.addr[DBITS-1:4] == ABASE[DBITS-1:4]);
    assign idx     = reg_e'(bus.addr[3:1]);
    assign wr      = bus.we && bus.sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hexout <= '0;
            ledr   <= '0;
            ledg   <= '0;
        end else if (wr) begin
            case (idx)
                R_HEX:   hexout <= bus.din[4*NDIGITS-1:0];
                R_LEDR:  ledr   <= bus.din[NLEDR-1:0];
                R_LEDG:  ledg   <= bus.din[NLEDG-1:0];
                default: ;
            endcase
        end
    end

    // A press is the edge on which a key's debounced level flips from released to pressed.
    always_comb begin
        key_press = '0;
        for (int unsigned i = 0; i < NKEYS; i++)
            key_press[i] = !kdata[i] && key_sync[i] && (deb_cnt[i] == '1);
        kstat_clr = (wr && idx == R_KSTAT) ? bus.din[NKEYS-1:0] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
            kdata    <= '0;
            kstat    <= '0;
            for (int unsigned i = 0; i < NKEYS; i++)
                deb_cnt[i] <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= ~key;
            key_sync <= key_meta;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (key_sync[i] == kdata[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == '1) begin
                    kdata[i]   <= key_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
            kstat <= (kstat & ~kstat_clr) | key_press;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [DBITS-1:0] tcnt, tlim;
    logic             tcnt_wr, tstat_clr, t_wrap;

    assign tcnt_wr   = wr && idx == R_TCNT;
    assign tstat_clr = wr && idx == R_KSTAT && bus.din[DBITS-1];
    // A CPU write to TCNT takes priority over the wrap, so it also suppresses TSTAT.
    assign t_wrap    = (tlim != '0) && (tcnt == tlim - 1'b1) && !tcnt_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= '0;
            tlim  <= '0;
            tstat <= 1'b0;
        end else begin
            if (wr && idx == R_TLIM)
                tlim <= bus.din;
            if (tcnt_wr)
                tcnt <= bus.din;
            else if (tlim != '0)
                tcnt <= t_wrap ? '0 : tcnt + 1'b1;
            tstat <= (tstat && !tstat_clr) || t_wrap;
        end
    end
`else
    assign tstat = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (bus.sel) begin
            case (idx)
                R_HEX:    rdata[4*NDIGITS-1:0] = hexout;
                R_LEDR:   rdata[NLEDR-1:0]     = ledr;
                R_LEDG:   rdata[NLEDG-1:0]     = ledg;
                R_KDATA:  rdata[NKEYS-1:0]     = kdata;
                R_SWDATA: rdata[NSW-1:0]       = sw_sync;
                R_KSTAT: begin
                    rdata[NKEYS-1:0] = kstat;
                    rdata[DBITS-1]   = tstat;
                end
`ifdef MMIO_TIMER_EN
                R_TCNT:   rdata = tcnt;
                R_TLIM:   rdata = tlim;
`endif
                default:  ;
            endcase
        end
    end

    assign bus.dout = rdata;
    assign irq      = (|kstat) || tstat;

endmodule
